asym_ram_narrow_reader: RTL

// Read-side engine for the asymmetric true-dual-port RAM: drives the narrow (WIDTHB) port read-only, sweeps a

---
 rtl/asym_ram_pkg.sv | 23 ++
 rtl/asym_ram_narrow_reader_if.sv | 17 +
 rtl/asym_ram_word_packer.sv | 28 ++
 rtl/asym_ram_narrow_reader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/asym_ram_pkg.sv
// Shared definitions for the asymmetric RAM narrow-port reader: FSM encodings,
// default geometry and the wide/narrow width ratio helper.
package asym_ram_pkg;

  typedef logic [1:0] stateT;

  localparam stateT S_IDLE  = 2'd0;
  localparam stateT S_ISSUE = 2'd1;
  localparam stateT S_DRAIN = 2'd2;
  localparam stateT S_OUT   = 2'd3;

  localparam int DEF_WIDTHA     = 16;
  localparam int DEF_WIDTHB     = 4;
  localparam int DEF_SIZEA      = 256;
  localparam int DEF_SIZEB      = 1024;
  localparam int DEF_ADDRWIDTHA = 8;
  localparam int DEF_ADDRWIDTHB = 10;

  function automatic int ratioOf(input int widthA, input int widthB);
    return widthA / widthB;
  endfunction

endpackage

// File: rtl/asym_ram_narrow_reader_if.sv
// Output word stream of the narrow reader.
// Handshake: a word transfers on every posedge where out_valid && out_ready; once
// out_valid is high, out_valid and out_data stay unchanged until that transfer.
interface asym_ram_narrow_reader_if
  import asym_ram_pkg::*;
#(
  parameter int WIDTHA = DEF_WIDTHA
) ();

  logic [WIDTHA-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/asym_ram_word_packer.sv
// Assembles one wide word from narrow read beats; beat k lands in slice k, so the
// lowest narrow address ends up least significant.
module asym_ram_word_packer #(
  parameter int WIDTHA = 16,
  parameter int WIDTHB = 4,
  parameter int RATIO  = 4,
  parameter int KW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capEn,
  input  logic [KW-1:0]     capIdx,
  input  logic [WIDTHB-1:0] capData,
  output logic [WIDTHA-1:0] word
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word <= '0;
    end else if (capEn) begin
      for (int i = 0; i < RATIO; i++) begin
        if (capIdx == KW'(i)) word[i*WIDTHB +: WIDTHB] <= capData;
      end
    end
  end

endmodule

// File: rtl/asym_ram_narrow_reader.sv
// Sweeps wide-word addresses through the narrow RAM port, reassembles RATIO narrow
// reads per word and streams the words out; the RAM port is never written.
module asym_ram_narrow_reader
  import asym_ram_pkg::*;
#(
  parameter int WIDTHA     = DEF_WIDTHA,
  parameter int WIDTHB     = DEF_WIDTHB,
  parameter int SIZEA      = DEF_SIZEA,
  parameter int SIZEB      = DEF_SIZEB,
  parameter int ADDRWIDTHA = DEF_ADDRWIDTHA,
  parameter int ADDRWIDTHB = DEF_ADDRWIDTHB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDRWIDTHA-1:0] start_addr,
  input  logic [ADDRWIDTHA:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  output logic [WIDTHB-1:0]     ram_di,
  input  logic [WIDTHB-1:0]     ram_do,
  asym_ram_narrow_reader_if.master outBus,
  output stateT                 dbgState
);

  localparam int RATIO = ratioOf(WIDTHA, WIDTHB);
  localparam int LOGR  = $clog2(RATIO);
  localparam int KW    = (LOGR > 0) ? LOGR : 1;
  localparam int LW    = ADDRWIDTHA + 1;

  if ((WIDTHA % WIDTHB) != 0 || (RATIO & (RATIO - 1)) != 0 ||
      ADDRWIDTHB != ADDRWIDTHA + LOGR || SIZEA != (1 << ADDRWIDTHA) ||
      SIZEB != SIZEA * RATIO) begin : gBadGeometry
    $error("asym_ram_narrow_reader: inconsistent width/depth parameters");
  end

  stateT                 state;
  logic [KW-1:0]         kCnt;
  logic [KW-1:0]         issuedK;
  logic [KW-1:0]         pendIdx;
  logic                  pendQ;
  logic [ADDRWIDTHA-1:0] wordAddr;
  logic [LW-1:0]         wordsLeft;
  logic                  outValidQ;
  logic                  accept;
  logic                  clearWord;

  assign accept   = outValidQ && outBus.out_ready;
  assign busy     = (state != S_IDLE);
  assign ram_we   = 1'b0;
  assign ram_di   = '0;
  assign dbgState = state;
  assign outBus.out_valid = outValidQ;

  always_comb begin
    clearWord = 1'b0;
    if (state == S_IDLE && start && num_words != '0) clearWord = 1'b1;
    if (state == S_OUT && accept && wordsLeft != LW'(1)) clearWord = 1'b1;
  end

  // pendQ/pendIdx mark the cycle in which the registered RAM output carries beat pendIdx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      kCnt      <= '0;
      issuedK   <= '0;
      pendIdx   <= '0;
      pendQ     <= 1'b0;
      wordAddr  <= '0;
      wordsLeft <= '0;
      outValidQ <= 1'b0;
      done      <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
    end else begin
      done    <= 1'b0;
      pendQ   <= ram_en;
      pendIdx <= issuedK;
      case (state)
        S_IDLE: begin
          ram_en <= 1'b0;
          if (start) begin
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              wordAddr  <= start_addr;
              wordsLeft <= num_words;
              kCnt      <= '0;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ram_en   <= 1'b1;
          ram_addr <= (ADDRWIDTHB'(wordAddr) << LOGR) | ADDRWIDTHB'(kCnt);
          issuedK  <= kCnt;
          kCnt     <= kCnt + KW'(1);
          if (kCnt == KW'(RATIO - 1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          ram_en <= 1'b0;
          if (pendQ && pendIdx == KW'(RATIO - 1)) begin
            state     <= S_OUT;
            outValidQ <= 1'b1;
          end
        end
        S_OUT: begin
          ram_en <= 1'b0;
          if (accept) begin
            outValidQ <= 1'b0;
            wordAddr  <= wordAddr + ADDRWIDTHA'(1);
            wordsLeft <= wordsLeft - LW'(1);
            if (wordsLeft == LW'(1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
              kCnt  <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  asym_ram_word_packer #(
    .WIDTHA(WIDTHA),
    .WIDTHB(WIDTHB),
    .RATIO (RATIO),
    .KW    (KW)
  ) uPacker (
    .clk    (clk),
    .rst    (rst),
    .clear  (clearWord),
    .capEn  (pendQ),
    .capIdx (pendIdx),
    .capData(ram_do),
    .word   (outBus.out_data)
  );

endmodule
